jtag_host_driver: RTL and testbench

Bit-banged IEEE 1149.1 host that drives the TCK/TMS/TDI/TRST pins of a TAP and samples TDO. It is the initiator counterpart to the test-access port on the chip's GPIO pads. It turns single-beat commands (IR scan, DR scan, TAP reset) into complete TAP state walks that start and end in Run-Test/Idle. It sits between a command source (logic analyzer or bus bridge) and the four JTAG pad signals.

---
 rtl/jtag_host_driver.sv | 230 +++++++++++++++++++++++
 tb/tb_jtag_host_driver.sv | 528 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/jtag_host_driver.sv
// jtag_host_driver: bit-banged IEEE 1149.1 host for a single TAP.
// Turns IR/DR scan and TAP reset commands into TCK/TMS/TDI walks from Run-Test/Idle.
module jtag_host_driver #(
   parameter int CLK_DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [4:0]  cmd_len,
   input  logic [31:0] cmd_data,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_data,
   output logic        busy,
   output logic        tck,
   output logic        tms,
   output logic        tdi,
   input  logic        tdo,
   output logic        trst_n
);

   localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [CW-1:0] DIV_LAST = CW'(CLK_DIV - 1);

   localparam logic [2:0] S_INIT = 3'd0;
   localparam logic [2:0] S_IDLE = 3'd1;
   localparam logic [2:0] S_PREP = 3'd2;
   localparam logic [2:0] S_SCAN = 3'd3;
   localparam logic [2:0] S_RESP = 3'd4;

   logic [2:0]    state_q, state_d;
   logic [CW-1:0] div_q, div_d;
   logic [5:0]    j_q, j_d;
   logic          rst_op_q, rst_op_d;
   logic          ir_op_q, ir_op_d;
   logic          rsp_en_q, rsp_en_d;
   logic [4:0]    len_q, len_d;
   logic [31:0]   data_q, data_d;
   logic          dat_q, dat_d;
   logic [4:0]    idx_q, idx_d;
   logic          tck_q, tck_d;
   logic          tms_q, tms_d;
   logic          tdi_q, tdi_d;
   logic          trst_q, trst_d;
   logic          busy_q, busy_d;
   logic          rdy_q, rdy_d;
   logic          rv_q, rv_d;
   logic [31:0]   rsp_q, rsp_d;

   logic [5:0] hdr, jn, last_j;
   logic [4:0] idx_n;
   logic       dn, tms_n, tdi_n;

   // Returns {data pulse, tms} for 0-based pulse j of the walk.
   function automatic logic [1:0] pulse_of(
      input logic [5:0] j,
      input logic       rst,
      input logic       ir,
      input logic [4:0] len
   );
      logic [5:0] h, dend;
      h = ir ? 6'd4 : 6'd3;
      dend = h + {1'b0, len};
      if (rst)
         pulse_of = {1'b0, j != 6'd5};
      else if (j < h)
         pulse_of = {1'b0, (j == 6'd0) || (ir && j == 6'd1)};
      else if (j <= dend)
         pulse_of = {1'b1, j == dend};
      else
         pulse_of = {1'b0, j == dend + 6'd1};
   endfunction

   always_comb begin
      hdr = ir_op_q ? 6'd4 : 6'd3;
      jn = (state_q == S_PREP) ? 6'd0 : j_q + 6'd1;
      {dn, tms_n} = pulse_of(jn, rst_op_q, ir_op_q, len_q);
      idx_n = 5'(jn - hdr);
      tdi_n = dn & data_q[idx_n];
      if (rst_op_q)
         last_j = 6'd5;
      else
         last_j = {1'b0, len_q} + (ir_op_q ? 6'd6 : 6'd5);
   end

   always_comb begin
      state_d  = state_q;
      div_d    = div_q;
      j_d      = j_q;
      rst_op_d = rst_op_q;
      ir_op_d  = ir_op_q;
      rsp_en_d = rsp_en_q;
      len_d    = len_q;
      data_d   = data_q;
      dat_d    = dat_q;
      idx_d    = idx_q;
      tck_d    = tck_q;
      tms_d    = tms_q;
      tdi_d    = tdi_q;
      trst_d   = trst_q;
      busy_d   = busy_q;
      rdy_d    = rdy_q;
      rv_d     = rv_q;
      rsp_d    = rsp_q;
      unique case (state_q)
         S_INIT: begin
            // Power-on walk: a TAP reset whose result nobody asked for.
            trst_d   = 1'b1;
            rst_op_d = 1'b1;
            ir_op_d  = 1'b0;
            rsp_en_d = 1'b0;
            state_d  = S_PREP;
         end
         S_IDLE: begin
            if (cmd_valid && rdy_q) begin
               rst_op_d = cmd_op[1];
               ir_op_d  = (cmd_op == 2'b01);
               len_d    = cmd_len;
               data_d   = cmd_data;
               rsp_en_d = 1'b1;
               rsp_d    = '0;
               busy_d   = 1'b1;
               rdy_d    = 1'b0;
               state_d  = S_PREP;
            end
         end
         S_PREP: begin
            tms_d   = tms_n;
            tdi_d   = tdi_n;
            dat_d   = dn;
            idx_d   = idx_n;
            j_d     = 6'd0;
            div_d   = '0;
            state_d = S_SCAN;
         end
         S_SCAN: begin
            if (div_q == DIV_LAST) begin
               div_d = '0;
               tck_d = ~tck_q;
               if (!tck_q) begin
                  if (dat_q)
                     rsp_d[idx_q] = tdo;
               end else if (j_q == last_j) begin
                  tms_d  = 1'b0;
                  tdi_d  = 1'b0;
                  dat_d  = 1'b0;
                  busy_d = 1'b0;
                  if (rsp_en_q) begin
                     rv_d    = 1'b1;
                     state_d = S_RESP;
                  end else begin
                     rdy_d   = 1'b1;
                     state_d = S_IDLE;
                  end
               end else begin
                  j_d   = jn;
                  tms_d = tms_n;
                  tdi_d = tdi_n;
                  dat_d = dn;
                  idx_d = idx_n;
               end
            end else begin
               div_d = div_q + 1'b1;
            end
         end
         S_RESP: begin
            if (rsp_ready) begin
               rv_d    = 1'b0;
               rdy_d   = 1'b1;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_INIT;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= S_INIT;
         div_q    <= '0;
         j_q      <= '0;
         rst_op_q <= 1'b1;
         ir_op_q  <= 1'b0;
         rsp_en_q <= 1'b0;
         len_q    <= '0;
         data_q   <= '0;
         dat_q    <= 1'b0;
         idx_q    <= '0;
         tck_q    <= 1'b0;
         tms_q    <= 1'b1;
         tdi_q    <= 1'b0;
         trst_q   <= 1'b0;
         busy_q   <= 1'b1;
         rdy_q    <= 1'b0;
         rv_q     <= 1'b0;
         rsp_q    <= '0;
      end else begin
         state_q  <= state_d;
         div_q    <= div_d;
         j_q      <= j_d;
         rst_op_q <= rst_op_d;
         ir_op_q  <= ir_op_d;
         rsp_en_q <= rsp_en_d;
         len_q    <= len_d;
         data_q   <= data_d;
         dat_q    <= dat_d;
         idx_q    <= idx_d;
         tck_q    <= tck_d;
         tms_q    <= tms_d;
         tdi_q    <= tdi_d;
         trst_q   <= trst_d;
         busy_q   <= busy_d;
         rdy_q    <= rdy_d;
         rv_q     <= rv_d;
         rsp_q    <= rsp_d;
      end
   end

   assign tck       = tck_q;
   assign tms       = tms_q;
   assign tdi       = tdi_q;
   assign trst_n    = trst_q;
   assign busy      = busy_q;
   assign cmd_ready = rdy_q;
   assign rsp_valid = rv_q;
   assign rsp_data  = rsp_q;

endmodule

// File: tb/tb_jtag_host_driver.sv
// tb_jtag_host_driver: directed bench for jtag_host_driver with CLK_DIV=2.
// A behavioural TAP (4-bit IR, length-following DR) sits on the JTAG pins.
module tb_jtag_host_driver;

   localparam int D = 2;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'b00;
   logic [4:0]  cmd_len = 5'd0;
   logic [31:0] cmd_data = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        busy;
   logic        tck;
   logic        tms;
   logic        tdi;
   logic        tdo = 1'b0;
   logic        trst_n;

   int n_run = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   jtag_host_driver #(.CLK_DIV(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_op    (cmd_op),
      .cmd_len   (cmd_len),
      .cmd_data  (cmd_data),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .busy      (busy),
      .tck       (tck),
      .tms       (tms),
      .tdi       (tdi),
      .tdo       (tdo),
      .trst_n    (trst_n)
   );

   // Behavioural TAP
   localparam int TLR = 0, RTI = 1, SELDR = 2, CAPDR = 3, SHDR = 4;
   localparam int EX1DR = 5, PAUDR = 6, EX2DR = 7, UPDDR = 8, SELIR = 9;
   localparam int CAPIR = 10, SHIR = 11, EX1IR = 12, PAUIR = 13;
   localparam int EX2IR = 14, UPDIR = 15;

   int          tap_st = TLR;
   int          tap_n = 0;
   logic [31:0] tap_sr = '0;
   logic [31:0] tap_dr = '0;
   logic [3:0]  tap_ir = '0;
   logic [31:0] pre_dr = '0;
   logic        load = 1'b0;

   function automatic int tap_next(input int s, input logic m);
      case (s)
         TLR:     return m ? TLR   : RTI;
         RTI:     return m ? SELDR : RTI;
         SELDR:   return m ? SELIR : CAPDR;
         CAPDR:   return m ? EX1DR : SHDR;
         SHDR:    return m ? EX1DR : SHDR;
         EX1DR:   return m ? UPDDR : PAUDR;
         PAUDR:   return m ? EX2DR : PAUDR;
         EX2DR:   return m ? UPDDR : SHDR;
         UPDDR:   return m ? SELDR : RTI;
         SELIR:   return m ? TLR   : CAPIR;
         CAPIR:   return m ? EX1IR : SHIR;
         SHIR:    return m ? EX1IR : SHIR;
         EX1IR:   return m ? UPDIR : PAUIR;
         PAUIR:   return m ? EX2IR : PAUIR;
         EX2IR:   return m ? UPDIR : SHIR;
         default: return m ? SELDR : RTI;
      endcase
   endfunction

   always @(posedge tck or negedge trst_n or posedge load) begin
      if (!trst_n) begin
         tap_st <= TLR;
      end else if (load) begin
         tap_dr <= pre_dr;
      end else begin
         case (tap_st)
            CAPDR: begin
               tap_sr <= tap_dr;
               tap_n  <= 0;
            end
            CAPIR: begin
               tap_sr <= 32'h1;
               tap_n  <= 0;
            end
            SHDR, SHIR: begin
               tap_sr <= {tdi, tap_sr[31:1]};
               tap_n  <= tap_n + 1;
            end
            UPDDR: tap_dr <= tap_sr >> (32 - tap_n);
            UPDIR: tap_ir <= 4'(tap_sr >> (32 - tap_n));
            default: ;
         endcase
         tap_st <= tap_next(tap_st, tms);
      end
   end

   always @(negedge tck or negedge trst_n) begin
      if (!trst_n)
         tdo <= 1'b0;
      else
         tdo <= (tap_st == SHDR || tap_st == SHIR) ? tap_sr[0] : 1'b0;
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic preload_dr(input logic [31:0] v);
      pre_dr = v;
      load = 1'b1;
      #1;
      load = 1'b0;
   endtask

   task automatic consume;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
   endtask

   // Issues one command and records pulses, TMS per pulse and the response edge.
   task automatic run_cmd(
      input  logic [1:0]  op,
      input  logic [4:0]  len,
      input  logic [31:0] data,
      output int          np,
      output logic [63:0] tmsv,
      output int          redge,
      output logic [31:0] r
   );
      int w;
      logic pt;
      np = 0;
      tmsv = '0;
      redge = -1;
      r = '0;
      w = 0;
      while (!cmd_ready && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      cmd_op = op;
      cmd_len = len;
      cmd_data = data;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      pt = tck;
      for (int e = 1; e < 400; e++) begin
         @(posedge clk);
         #1;
         if (tck && !pt) begin
            if (np < 64) tmsv[np] = tms;
            np++;
         end
         pt = tck;
         if (rsp_valid) begin
            redge = e;
            r = rsp_data;
            break;
         end
      end
   endtask

   // Watches the automatic walk that follows reset release.
   task automatic observe_init(
      output int          np,
      output logic [63:0] tmsv,
      output int          ready_e,
      output logic        rsp_seen,
      output logic        trst_ok,
      output logic        width_ok
   );
      logic pt;
      int rise_e, fall_e;
      np = 0;
      tmsv = '0;
      ready_e = -1;
      rsp_seen = 1'b0;
      trst_ok = 1'b0;
      width_ok = 1'b1;
      rise_e = -1;
      fall_e = -1;
      pt = 1'b0;
      for (int e = 0; e < 60; e++) begin
         @(posedge clk);
         #1;
         if (e == 0) trst_ok = trst_n && !tck;
         if (tck && !pt) begin
            if (np < 64) tmsv[np] = tms;
            np++;
            if (fall_e >= 0 && (e - fall_e) != D) width_ok = 1'b0;
            rise_e = e;
         end
         if (!tck && pt) begin
            if ((e - rise_e) != D) width_ok = 1'b0;
            fall_e = e;
         end
         pt = tck;
         if (cmd_ready && ready_e < 0) ready_e = e;
         if (rsp_valid) rsp_seen = 1'b1;
      end
   endtask

   task automatic test_reset;
      int np, re;
      logic [63:0] tv;
      logic rs, tok, wok;
      #2;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_run++;
      if ({tck, tms, tdi, trst_n, busy, cmd_ready, rsp_valid} !== 7'b0100100) begin
         n_fail++;
         $display("FAIL reset_pins: got %b want 0100100",
                  {tck, tms, tdi, trst_n, busy, cmd_ready, rsp_valid});
      end
      n_run++;
      if (rsp_data !== 32'h0) begin
         n_fail++;
         $display("FAIL reset_rsp_data: got %h want 00000000", rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      observe_init(np, tv, re, rs, tok, wok);
      n_run++;
      if (tok !== 1'b1) begin
         n_fail++;
         $display("FAIL init_trst: got %b want 1", tok);
      end
      n_run++;
      if (np != 6 || tv[5:0] !== 6'h1F) begin
         n_fail++;
         $display("FAIL init_tms: got %0d pulses tms %h want 6 pulses tms 1f", np, tv[5:0]);
      end
      n_run++;
      if (wok !== 1'b1) begin
         n_fail++;
         $display("FAIL init_width: got bad tck widths want %0d clk high/low", D);
      end
      n_run++;
      if (re != 25) begin
         n_fail++;
         $display("FAIL init_ready_edge: got %0d want 25", re);
      end
      n_run++;
      if (rs !== 1'b0) begin
         n_fail++;
         $display("FAIL init_no_rsp: got rsp_valid seen want none");
      end
      n_run++;
      if ({tck, tms, tdi, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL init_idle_pins: got %b want 0000", {tck, tms, tdi, busy});
      end
   endtask

   task automatic test_dr8;
      int np, re;
      logic [63:0] tv;
      logic [31:0] r;
      preload_dr(32'h0000_003C);
      run_cmd(2'b00, 5'd7, 32'h0000_00A5, np, tv, re, r);
      n_run++;
      if (np != 13 || tv[12:0] !== 13'h0C01) begin
         n_fail++;
         $display("FAIL dr8_tms: got %0d pulses tms %h want 13 pulses tms 0c01", np, tv[12:0]);
      end
      n_run++;
      if (re != 53) begin
         n_fail++;
         $display("FAIL dr8_rsp_edge: got %0d want 53", re);
      end
      n_run++;
      if (r !== 32'h0000_003C) begin
         n_fail++;
         $display("FAIL dr8_rsp_data: got %h want 0000003c", r);
      end
      n_run++;
      if (tap_dr !== 32'h0000_00A5 || tap_st != RTI) begin
         n_fail++;
         $display("FAIL dr8_tap: got dr %h st %0d want dr 000000a5 st 1", tap_dr, tap_st);
      end
      n_run++;
      if ({tck, tms, tdi, busy} !== 4'b0000) begin
         n_fail++;
         $display("FAIL dr8_idle_pins: got %b want 0000", {tck, tms, tdi, busy});
      end
      consume();
   endtask

   task automatic test_ir4;
      int np, re;
      logic [63:0] tv;
      logic [31:0] r;
      run_cmd(2'b01, 5'd3, 32'h0000_000E, np, tv, re, r);
      n_run++;
      if (np != 10 || tv[9:0] !== 10'h183) begin
         n_fail++;
         $display("FAIL ir4_tms: got %0d pulses tms %h want 10 pulses tms 183", np, tv[9:0]);
      end
      n_run++;
      if (re != 41) begin
         n_fail++;
         $display("FAIL ir4_rsp_edge: got %0d want 41", re);
      end
      n_run++;
      if (r !== 32'h0000_0001 || tap_ir !== 4'hE) begin
         n_fail++;
         $display("FAIL ir4_result: got rsp %h ir %h want rsp 00000001 ir e", r, tap_ir);
      end
      consume();
   endtask

   task automatic test_dr32;
      int np, re;
      logic [63:0] tv;
      logic [31:0] r;
      preload_dr(32'h1234_5678);
      run_cmd(2'b00, 5'd31, 32'hDEAD_BEEF, np, tv, re, r);
      n_run++;
      if (np != 37 || tv[36:0] !== 37'h0C_0000_0001) begin
         n_fail++;
         $display("FAIL dr32_tms: got %0d pulses tms %h want 37 pulses tms 0c00000001",
                  np, tv[36:0]);
      end
      n_run++;
      if (re != 149) begin
         n_fail++;
         $display("FAIL dr32_rsp_edge: got %0d want 149", re);
      end
      n_run++;
      if (r !== 32'h1234_5678 || tap_dr !== 32'hDEAD_BEEF) begin
         n_fail++;
         $display("FAIL dr32_result: got rsp %h dr %h want rsp 12345678 dr deadbeef", r, tap_dr);
      end
      consume();
   endtask

   task automatic test_tap_reset;
      int np, re;
      logic [63:0] tv;
      logic [31:0] r;
      logic [1:0] ops [2];
      ops[0] = 2'b10;
      ops[1] = 2'b11;
      for (int k = 0; k < 2; k++) begin
         run_cmd(ops[k], 5'd5, 32'hFFFF_FFFF, np, tv, re, r);
         n_run++;
         if (np != 6 || tv[5:0] !== 6'h1F || re != 25) begin
            n_fail++;
            $display("FAIL tap_reset_op%0d: got %0d pulses tms %h edge %0d want 6 1f 25",
                     ops[k], np, tv[5:0], re);
         end
         n_run++;
         if (r !== 32'h0 || tap_st != RTI) begin
            n_fail++;
            $display("FAIL tap_reset_rsp_op%0d: got rsp %h st %0d want 00000000 st 1",
                     ops[k], r, tap_st);
         end
         consume();
      end
   endtask

   task automatic test_back_to_back;
      int np, re;
      logic [63:0] tv;
      logic [31:0] r;
      preload_dr(32'h89AB_CDEF);
      run_cmd(2'b00, 5'd15, 32'h0000_1234, np, tv, re, r);
      n_run++;
      if (r !== 32'h0000_CDEF) begin
         n_fail++;
         $display("FAIL bp_first_rsp: got %h want 0000cdef", r);
      end
      cmd_op = 2'b00;
      cmd_len = 5'd7;
      cmd_data = 32'h0000_005A;
      cmd_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         @(posedge clk);
         #1;
         n_run++;
         if ({rsp_valid, cmd_ready, tck, busy, rsp_data} !== {4'b1000, 32'h0000_CDEF}) begin
            n_fail++;
            $display("FAIL bp_hold_%0d: got v%b r%b tck%b busy%b data %h want v1 r0 tck0 busy0 cdef",
                     c, rsp_valid, cmd_ready, tck, busy, rsp_data);
         end
      end
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      n_run++;
      if ({rsp_valid, cmd_ready, busy} !== 3'b010) begin
         n_fail++;
         $display("FAIL bp_release: got %b want 010", {rsp_valid, cmd_ready, busy});
      end
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      n_run++;
      if ({cmd_ready, busy} !== 2'b01) begin
         n_fail++;
         $display("FAIL bp_accept: got %b want 01", {cmd_ready, busy});
      end
      re = -1;
      for (int e = 1; e < 200; e++) begin
         @(posedge clk);
         #1;
         if (rsp_valid) begin
            re = e;
            break;
         end
      end
      n_run++;
      if (re != 53 || rsp_data !== 32'h0000_0034 || tap_dr !== 32'h0000_005A) begin
         n_fail++;
         $display("FAIL bp_second: got edge %0d rsp %h dr %h want 53 00000034 0000005a",
                  re, rsp_data, tap_dr);
      end
      consume();
   endtask

   task automatic test_midreset;
      int np, re, w;
      logic [63:0] tv;
      logic [31:0] r;
      logic rs, tok, wok, pt;
      preload_dr(32'h0000_00C3);
      w = 0;
      while (!cmd_ready && w < 200) begin
         @(posedge clk);
         #1;
         w++;
      end
      cmd_op = 2'b00;
      cmd_len = 5'd7;
      cmd_data = 32'h0000_00FF;
      cmd_valid = 1'b1;
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      np = 0;
      pt = tck;
      for (int e = 0; e < 200 && np < 8; e++) begin
         @(posedge clk);
         #1;
         if (tck && !pt) np++;
         pt = tck;
      end
      n_run++;
      if (np != 8) begin
         n_fail++;
         $display("FAIL mid_reach_pulse: got %0d pulses want 8", np);
      end
      rst_n = 1'b0;
      #1;
      n_run++;
      if ({tck, tms, tdi, trst_n, busy, cmd_ready, rsp_valid} !== 7'b0100100) begin
         n_fail++;
         $display("FAIL mid_reset_pins: got %b want 0100100",
                  {tck, tms, tdi, trst_n, busy, cmd_ready, rsp_valid});
      end
      repeat (3) @(posedge clk);
      #1;
      n_run++;
      if ({tck, rsp_valid, rsp_data} !== 34'h0) begin
         n_fail++;
         $display("FAIL mid_reset_hold: got tck %b v %b data %h want 0 0 0",
                  tck, rsp_valid, rsp_data);
      end
      @(negedge clk);
      rst_n = 1'b1;
      observe_init(np, tv, re, rs, tok, wok);
      n_run++;
      if (np != 6 || tv[5:0] !== 6'h1F || re != 25 || rs !== 1'b0 || tok !== 1'b1) begin
         n_fail++;
         $display("FAIL mid_reinit: got %0d pulses tms %h ready %0d rsp %b trst %b want 6 1f 25 0 1",
                  np, tv[5:0], re, rs, tok);
      end
      n_run++;
      if (tap_dr !== 32'h0000_00C3) begin
         n_fail++;
         $display("FAIL mid_no_update: got dr %h want 000000c3", tap_dr);
      end
      run_cmd(2'b00, 5'd7, 32'h0000_0066, np, tv, re, r);
      n_run++;
      if (re != 53 || r !== 32'h0000_00C3 || tap_dr !== 32'h0000_0066) begin
         n_fail++;
         $display("FAIL mid_next_scan: got edge %0d rsp %h dr %h want 53 000000c3 00000066",
                  re, r, tap_dr);
      end
      consume();
   endtask

   initial begin
      test_reset();
      test_dr8();
      test_ir4();
      test_dr32();
      test_tap_reset();
      test_back_to_back();
      test_midreset();
      $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
      $finish;
   end

endmodule
